// File: rtl/bmem_responder.sv
// Burst-memory responder: stores LINES x 256-bit lines and transfers each line
// as four 64-bit beats. Reads are queued with a snapshot of the line and are
// answered in order after a fixed latency.
module bmem_responder #(
    parameter int unsigned LINES    = 64,
    parameter int unsigned READ_LAT = 6,
    parameter int unsigned Q_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid
);

    localparam int unsigned IW  = $clog2(LINES);
    localparam int unsigned CDW = $clog2(READ_LAT);
    localparam int unsigned QW  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(Q_DEPTH + 1);

    typedef enum logic {
        W_IDLE,
        W_BURST
    } wstate_t;

    // Backing store
    logic [255:0]   mem [LINES];

    // Write burst assembly
    wstate_t        w_state;
    logic [IW-1:0]  w_idx;
    logic [1:0]     w_beat;
    logic [191:0]   w_buf;

    // Read queue: address, data snapshot and per-entry countdown
    logic [31:0]    q_addr [Q_DEPTH];
    logic [255:0]   q_data [Q_DEPTH];
    logic [CDW-1:0] q_cd   [Q_DEPTH];
    logic [QW-1:0]  wr_ptr;
    logic [QW-1:0]  rd_ptr;
    logic [QW-1:0]  rd_ptr_next;
    logic [CW-1:0]  q_count;

    // Response engine
    logic [1:0]     beat;
    logic [1:0]     beat_next;

    logic [IW-1:0]  req_idx;
    logic           wr_start;
    logic           accept;
    logic           pop;
    logic [QW-1:0]  cand_ptr;
    logic           cand_avail;
    logic           launch;
    logic [4:0]     unused_addr_lo;

    // Offset bits within a line carry no information.
    assign unused_addr_lo = bmem_addr[4:0];

    assign req_idx    = bmem_addr[5 +: IW];
    assign bmem_ready = !rst && ((w_state == W_BURST) || (q_count != CW'(Q_DEPTH)));
    assign wr_start   = (w_state == W_IDLE) && bmem_ready && bmem_write;
    assign accept     = (w_state == W_IDLE) && bmem_ready && bmem_read && !bmem_write;
    assign pop        = bmem_rvalid && (beat == 2'd3);
    assign beat_next  = beat + 2'd1;

    assign rd_ptr_next = (rd_ptr == QW'(Q_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    // Entry that would start next: the one behind the head if the head is
    // finishing this cycle, otherwise the head itself. A countdown of 1 here
    // reaches 0 at this edge, so beat 0 goes out right after it.
    assign cand_ptr   = pop ? rd_ptr_next : rd_ptr;
    assign cand_avail = pop ? (q_count > CW'(1)) : (q_count != '0);
    assign launch     = (!bmem_rvalid || pop) && cand_avail && (q_cd[cand_ptr] <= CDW'(1));

    // Write FSM and line storage; a line is committed only when beat 3 lands
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LINES); i++) begin
                mem[i] <= '0;
            end
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_beat  <= '0;
            w_buf   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_start) begin
                        w_idx        <= req_idx;
                        w_buf[63:0]  <= bmem_wdata;
                        w_beat       <= 2'd1;
                        w_state      <= W_BURST;
                    end
                end
                W_BURST: begin
                    if (bmem_write) begin
                        if (w_beat == 2'd3) begin
                            mem[w_idx] <= {bmem_wdata, w_buf};
                            w_beat     <= '0;
                            w_state    <= W_IDLE;
                        end else begin
                            w_buf[{w_beat, 6'd0} +: 64] <= bmem_wdata;
                            w_beat                      <= w_beat + 2'd1;
                        end
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Capture address and line snapshot for an accepted read
    always_ff @(posedge clk) begin
        if (accept) begin
            q_addr[wr_ptr] <= {bmem_addr[31:5], 5'b0};
            q_data[wr_ptr] <= mem[req_idx];
        end
    end

    // Queue pointers, occupancy and per-entry countdowns
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                q_cd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                if (q_cd[i] != '0) begin
                    q_cd[i] <= q_cd[i] - 1'b1;
                end
            end
            if (accept) begin
                q_cd[wr_ptr] <= CDW'(READ_LAT - 1);
                wr_ptr       <= (wr_ptr == QW'(Q_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_next;
            end
            case ({accept, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Response engine: four uninterrupted beats per entry, back to back
    always_ff @(posedge clk) begin
        if (rst) begin
            bmem_rvalid <= 1'b0;
            bmem_raddr  <= '0;
            bmem_rdata  <= '0;
            beat        <= '0;
        end else if (launch) begin
            bmem_rvalid <= 1'b1;
            bmem_raddr  <= q_addr[cand_ptr];
            bmem_rdata  <= q_data[cand_ptr][63:0];
            beat        <= '0;
        end else if (pop) begin
            bmem_rvalid <= 1'b0;
            beat        <= '0;
        end else if (bmem_rvalid) begin
            bmem_rdata  <= q_data[rd_ptr][{beat_next, 6'd0} +: 64];
            beat        <= beat_next;
        end
    end

endmodule

// File: tb/tb_bmem_responder.sv
// Directed bench for bmem_responder: write/read bursts, gaps, queue flow
// control, snapshot ordering, address aliasing and mid-transfer reset.
module tb_bmem_responder;

    localparam int unsigned L = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    logic [31:0] m_addr [$];
    logic [63:0] m_data [$];
    int          m_cyc  [$];

    bmem_responder #(
        .LINES    (64),
        .READ_LAT (L),
        .Q_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Record every read beat away from the active edge
    always @(negedge clk) begin
        if (!rst && bmem_rvalid) begin
            m_addr.push_back(bmem_raddr);
            m_data.push_back(bmem_rdata);
            m_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        m_addr.delete();
        m_data.delete();
        m_cyc.delete();
    endtask

    task automatic write_line(input logic [31:0] a, input logic [255:0] line);
        bmem_addr  = a;
        bmem_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bmem_wdata = line[i*64 +: 64];
            tick();
        end
        bmem_write = 1'b0;
    endtask

    task automatic read_line(input logic [31:0] a, output int acc);
        check("rd_ready", 64'(bmem_ready), 64'd1);
        bmem_addr = a;
        bmem_read = 1'b1;
        acc       = cyc;
        tick();
        bmem_read = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k;
        k = 0;
        while (m_data.size() < n && k < 200) begin
            tick();
            k++;
        end
        check(tag, 64'(m_data.size()), 64'(n));
    endtask

    task automatic check_line(input string tag, input int base, input logic [31:0] a,
                              input logic [255:0] line);
        if (m_data.size() < base + 4) begin
            check({tag, "_missing"}, 64'(m_data.size()), 64'(base + 4));
            return;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_a%0d", tag, i), 64'(m_addr[base+i]), 64'(a));
            check($sformatf("%s_d%0d", tag, i), m_data[base+i], line[i*64 +: 64]);
            check($sformatf("%s_c%0d", tag, i), 64'(m_cyc[base+i]), 64'(m_cyc[base] + i));
        end
    endtask

    logic [255:0] l1, l2, l4, l5, l6;
    logic [255:0] exp_lines [5];
    logic [31:0]  t3_addr   [5];
    int           acc, acc0, k, seen;

    initial begin
        l1 = {64'h4444444444444444, 64'h3333333333333333,
              64'h2222222222222222, 64'h1111111111111111};
        l2 = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
              64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
        l4 = {64'h0404040404040404, 64'h0303030303030303,
              64'h0202020202020202, 64'h0101010101010101};
        l5 = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2,
              64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
        l6 = {64'h6666666666666663, 64'h6666666666666662,
              64'h6666666666666661, 64'h6666666666666660};

        rst        = 1'b1;
        bmem_addr  = '0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        repeat (3) tick();
        check("rst_ready", 64'(bmem_ready), 64'd0);
        check("rst_rvalid", 64'(bmem_rvalid), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(bmem_ready), 64'd1);
        check("post_rst_rvalid", 64'(bmem_rvalid), 64'd0);
        check("post_rst_raddr", 64'(bmem_raddr), 64'd0);
        check("post_rst_rdata", bmem_rdata, 64'd0);

        // Back-to-back write, then read with latency check
        write_line(32'h40, l1);
        clear_mon();
        read_line(32'h40, acc);
        wait_beats("t1_beats", 4);
        repeat (8) tick();
        check("t1_exact4", 64'(m_data.size()), 64'd4);
        check_line("t1", 0, 32'h40, l1);
        check("t1_lat", 64'(m_cyc[0] - acc), 64'(L));

        // Write with a two-cycle gap; a read during the gap is ignored
        clear_mon();
        bmem_addr  = 32'h60;
        bmem_write = 1'b1;
        bmem_wdata = l2[63:0];
        tick();
        bmem_wdata = l2[127:64];
        tick();
        bmem_write = 1'b0;
        bmem_read  = 1'b1;
        check("t2_gap_ready", 64'(bmem_ready), 64'd1);
        repeat (2) tick();
        bmem_read  = 1'b0;
        bmem_write = 1'b1;
        bmem_wdata = l2[191:128];
        tick();
        bmem_wdata = l2[255:192];
        tick();
        bmem_write = 1'b0;
        repeat (15) tick();
        check("t2_gap_read", 64'(m_data.size()), 64'd0);
        read_line(32'h60, acc);
        wait_beats("t2_beats", 4);
        check_line("t2", 0, 32'h60, l2);

        // Five consecutive reads against a four-deep queue
        repeat (4) tick();
        clear_mon();
        t3_addr   = '{32'h40, 32'h60, 32'h80, 32'hA0, 32'hC0};
        exp_lines = '{l1, l2, 256'd0, 256'd0, 256'd0};
        acc0 = cyc;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_ready%0d", i), 64'(bmem_ready), 64'd1);
            bmem_addr = t3_addr[i];
            bmem_read = 1'b1;
            tick();
        end
        bmem_addr = t3_addr[4];
        check("t3_ready_low", 64'(bmem_ready), 64'd0);
        k = 0;
        while (!bmem_ready && k < 50) begin
            tick();
            k++;
        end
        check("t3_ready_rise", 64'(cyc), 64'(acc0 + L + 4));
        tick();
        bmem_read = 1'b0;
        wait_beats("t3_beats", 20);
        if (m_data.size() >= 20) begin
            check("t3_lat", 64'(m_cyc[0] - acc0), 64'(L));
            for (int j = 0; j < 5; j++) begin
                check_line($sformatf("t3_e%0d", j), 4 * j, t3_addr[j], exp_lines[j]);
                check($sformatf("t3_contig%0d", j), 64'(m_cyc[4*j]), 64'(m_cyc[0] + 4 * j));
            end
        end

        // Snapshot: read then immediate write of the same line
        repeat (4) tick();
        clear_mon();
        read_line(32'h80, acc);
        write_line(32'h80, l4);
        wait_beats("t4_beats_old", 4);
        check_line("t4_old", 0, 32'h80, 256'd0);
        repeat (4) tick();
        clear_mon();
        read_line(32'h80, acc);
        wait_beats("t4_beats_new", 4);
        check_line("t4_new", 0, 32'h80, l4);

        // Upper-bit aliasing and ignored offset bits
        repeat (4) tick();
        write_line(32'h0, l5);
        clear_mon();
        read_line(32'hFFFFF81F, acc);
        wait_beats("t5_beats", 4);
        check_line("t5", 0, 32'hFFFFF800, l5);

        // Reset during response beat 2, then during write beat 1
        repeat (4) tick();
        write_line(32'h20, l6);
        clear_mon();
        read_line(32'h20, acc);
        seen = 0;
        k    = 0;
        while (seen < 3 && k < 40) begin
            tick();
            k++;
            if (bmem_rvalid) seen++;
        end
        check("t6_reached_beat2", 64'(seen), 64'd3);
        rst = 1'b1;
        tick();
        check("t6_rst_rvalid", 64'(bmem_rvalid), 64'd0);
        check("t6_rst_ready", 64'(bmem_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("t6_ready_after", 64'(bmem_ready), 64'd1);
        check("t6_rvalid_after", 64'(bmem_rvalid), 64'd0);
        bmem_addr  = 32'hE0;
        bmem_write = 1'b1;
        bmem_wdata = l6[63:0];
        tick();
        bmem_wdata = l6[127:64];
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        bmem_write = 1'b0;
        #1;
        check("t6_wr_ready_after", 64'(bmem_ready), 64'd1);
        clear_mon();
        repeat (12) tick();
        check("t6_no_stale", 64'(m_data.size()), 64'd0);
        read_line(32'h20, acc);
        read_line(32'hE0, acc);
        wait_beats("t6_beats", 8);
        check_line("t6_rd20", 0, 32'h20, 256'd0);
        check_line("t6_rdE0", 4, 32'hE0, 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
